// File: rtl/onehot_decoder_stream.sv
// Registered binary-to-one-hot decoder with valid/ready handshakes and a
// built-in sweep mode that emits every one-hot code in ascending order.
module onehot_decoder_stream #(
    parameter int unsigned N = 64,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_idx,
    input  logic         sweep_start,
    output logic         sweep_busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         out_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t       state;
    state_t       state_n;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_n;
    logic         load;
    logic [N-1:0] load_y;
    logic         load_err;
    logic         out_free;
    logic         in_range;

    assign out_free   = !out_valid || out_ready;
    assign in_range   = 32'(in_idx) < N;
    assign sweep_busy = (state == SWEEP);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, sweep counter and output-stage load decision
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        load     = 1'b0;
        load_y   = '0;
        load_err = 1'b0;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n && enable && out_free && !sweep_start;
                if (enable && sweep_start) begin
                    state_n = SWEEP;
                    cnt_n   = '0;
                end else if (in_valid && in_ready) begin
                    load     = 1'b1;
                    load_y   = in_range ? (N'(1) << in_idx) : '0;
                    load_err = !in_range;
                end
            end
            SWEEP: begin
                if (enable && out_free) begin
                    load   = 1'b1;
                    load_y = N'(1) << cnt;
                    // Counter stops at the last code rather than wrapping
                    if (cnt == W'(N - 1)) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Sweep counter and output register stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            out_err   <= 1'b0;
        end else begin
            cnt <= cnt_n;
            if (load) begin
                out_valid <= 1'b1;
                y         <= load_y;
                out_err   <= load_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Scoreboard bench for onehot_decoder_stream: a 64-wide instance for decode,
// backpressure and sweep scenarios, and a 10-wide instance for out-of-range.
module tb_onehot_decoder_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, enable_a, in_valid_a, in_ready_a, sweep_start_a;
    logic        sweep_busy_a, out_valid_a, out_ready_a, out_err_a;
    logic [5:0]  in_idx_a;
    logic [63:0] y_a;

    logic        rst_n_b, enable_b, in_valid_b, in_ready_b, sweep_start_b;
    logic        sweep_busy_b, out_valid_b, out_ready_b, out_err_b;
    logic [3:0]  in_idx_b;
    logic [9:0]  y_b;

    onehot_decoder_stream #(.N(64)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .enable(enable_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_idx(in_idx_a),
        .sweep_start(sweep_start_a), .sweep_busy(sweep_busy_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .y(y_a), .out_err(out_err_a)
    );

    onehot_decoder_stream #(.N(10)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .enable(enable_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_idx(in_idx_b),
        .sweep_start(sweep_start_b), .sweep_busy(sweep_busy_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .y(y_b), .out_err(out_err_b)
    );

    typedef struct packed {
        logic [63:0] y;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // Monitors: a beat is consumed when valid and ready meet at a clock edge
    always @(negedge clk) begin
        if (rst_n_a && out_valid_a && out_ready_a) begin
            if (qa.size() == 0) begin
                total++;
                $display("FAIL unexpected_beat_a: actual=%h required=none", y_a);
            end else begin
                ea = qa.pop_front();
                check("beat_y_a", y_a, ea.y);
                check("beat_err_a", 64'(out_err_a), 64'(ea.err));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n_b && out_valid_b && out_ready_b) begin
            if (qb.size() == 0) begin
                total++;
                $display("FAIL unexpected_beat_b: actual=%h required=none", y_b);
            end else begin
                eb = qb.pop_front();
                check("beat_y_b", 64'(y_b), eb.y);
                check("beat_err_b", 64'(out_err_b), 64'(eb.err));
            end
        end
    end

    task automatic send_a(input logic [5:0] idx, input logic [63:0] ey, input logic ee);
        bit ok = 0;
        in_valid_a = 1'b1;
        in_idx_a   = idx;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready_a) begin
                qa.push_back('{ey, ee});
                ok = 1;
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        in_valid_a = 1'b0;
        if (!ok) fail_now("send_a");
    endtask

    task automatic send_b(input logic [3:0] idx, input logic [63:0] ey, input logic ee);
        bit ok = 0;
        in_valid_b = 1'b1;
        in_idx_b   = idx;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready_b) begin
                qb.push_back('{ey, ee});
                ok = 1;
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        in_valid_b = 1'b0;
        if (!ok) fail_now("send_b");
    endtask

    task automatic drain_a();
        for (int k = 0; k < 100 && qa.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_a", 64'(qa.size()), 64'd0);
    endtask

    task automatic drain_b();
        for (int k = 0; k < 100 && qb.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_b", 64'(qb.size()), 64'd0);
    endtask

    // Pulses sweep_start for one cycle and queues the 64 expected sweep beats
    task automatic start_sweep_a();
        sweep_start_a = 1'b1;
        for (int i = 0; i < 64; i++) qa.push_back('{64'd1 << i, 1'b0});
        @(posedge clk); #1;
        sweep_start_a = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        bit done;
        rst_n_a = 0; enable_a = 1; in_valid_a = 0; in_idx_a = '0; sweep_start_a = 0; out_ready_a = 1;
        rst_n_b = 0; enable_b = 1; in_valid_b = 0; in_idx_b = '0; sweep_start_b = 0; out_ready_b = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_y", y_a, 64'd0);
        check("rst_out_err", 64'(out_err_a), 64'd0);
        check("rst_sweep_busy", 64'(sweep_busy_a), 64'd0);
        check("rst_in_ready", 64'(in_ready_a), 64'd0);
        rst_n_a = 1; rst_n_b = 1;
        @(posedge clk); #1;

        // Basic back-to-back decode
        send_a(6'd0, 64'h0000_0000_0000_0001, 1'b0);
        check("latency_valid", 64'(out_valid_a), 64'd1);
        check("latency_y", y_a, 64'h1);
        send_a(6'd1, 64'h0000_0000_0000_0002, 1'b0);
        send_a(6'd37, 64'h0000_0020_0000_0000, 1'b0);
        send_a(6'd63, 64'h8000_0000_0000_0000, 1'b0);
        drain_a();

        // Out of range on the 10-wide instance, then reset with a beat pending
        send_b(4'd12, 64'h0, 1'b1);
        send_b(4'd9, 64'h200, 1'b0);
        drain_b();
        out_ready_b = 1'b0;
        send_b(4'd4, 64'h10, 1'b0);
        check("b_pending_valid", 64'(out_valid_b), 64'd1);
        rst_n_b = 1'b0;
        @(posedge clk); #1;
        qb.delete();
        check("b_rst_valid", 64'(out_valid_b), 64'd0);
        check("b_rst_y", 64'(y_b), 64'd0);
        check("b_rst_err", 64'(out_err_b), 64'd0);
        check("b_rst_in_ready", 64'(in_ready_b), 64'd0);
        rst_n_b = 1'b1; out_ready_b = 1'b1;

        // Backpressure: beat 5 held, then drained while 6 is accepted
        out_ready_a = 1'b0;
        send_a(6'd5, 64'h20, 1'b0);
        in_valid_a = 1'b1;
        in_idx_a   = 6'd6;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_y_stable", y_a, 64'h20);
            check("bp_in_ready", 64'(in_ready_a), 64'd0);
            @(posedge clk); #1;
        end
        out_ready_a = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready_a), 64'd1);
        qa.push_back('{64'h40, 1'b0});
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        drain_a();

        // Full sweep with in_valid held and a stray sweep_start mid-way
        in_valid_a = 1'b1;
        in_idx_a   = 6'd7;
        start_sweep_a();
        busy_cnt = 0;
        done     = 0;
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (sweep_busy_a) begin
                busy_cnt++;
                if (in_ready_a !== 1'b0) check("sweep_in_ready_busy", 64'(in_ready_a), 64'd0);
            end else if (busy_cnt > 0) begin
                check("sweep_in_ready_after", 64'(in_ready_a), 64'd1);
                if (in_ready_a) qa.push_back('{64'h80, 1'b0});
                done = 1;
            end
            @(posedge clk); #1;
            sweep_start_a = (k == 10);
            if (done) break;
        end
        in_valid_a = 1'b0;
        sweep_start_a = 1'b0;
        check("sweep_busy_cycles", 64'(busy_cnt), 64'd64);
        if (!done) fail_now("sweep_end");
        drain_a();

        // Enable pause after beat 20
        start_sweep_a();
        repeat (21) @(posedge clk);
        #1;
        check("pause_beat20", y_a, 64'd1 << 20);
        enable_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("pause_no_beat", 64'(out_valid_a), 64'd0);
        end
        check("pause_busy_held", 64'(sweep_busy_a), 64'd1);
        enable_a = 1'b1;
        for (int k = 0; k < 100 && sweep_busy_a; k++) @(posedge clk);
        drain_a();

        // Reset while beat 30 is presented
        start_sweep_a();
        repeat (31) @(posedge clk);
        #1;
        check("midrst_beat30", y_a, 64'd1 << 30);
        check("midrst_q_left", 64'(qa.size()), 64'd34);
        rst_n_a = 1'b0;
        @(posedge clk); #1;
        qa.delete();
        check("midrst_valid", 64'(out_valid_a), 64'd0);
        check("midrst_busy", 64'(sweep_busy_a), 64'd0);
        rst_n_a = 1'b1;
        @(posedge clk); #1;
        send_a(6'd3, 64'h8, 1'b0);
        drain_a();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
